// File: rtl/mmio_bus_responder.sv
// Data-port responder: decodes CPU accesses to DM, two countdown timers and the
// external-interrupt acknowledge word, and builds the HWInt vector for CP0.

module mmio_bus_responder_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_preset,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_ctrl,
  output logic [31:0] o_preset,
  output logic [31:0] o_count,
  output logic        o_irq,
  output logic [1:0]  o_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;
  logic        w_auto;

  // Only MODE 01 reloads; every other encoding behaves as one-shot.
  assign w_auto = (r_ctrl[2:1] == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_irq    <= 1'b0;
    end else if (i_wr_ctrl || i_wr_preset) begin
      // A CPU write pre-empts whatever the counter was about to do.
      if (i_wr_ctrl)   r_ctrl   <= i_wdata[3:0];
      if (i_wr_preset) r_preset <= i_wdata;
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_auto) r_irq <= 1'b0;
          if (r_ctrl[0]) r_state <= LOAD;
        end
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
        end
        CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // Presets of 0 and 1 both land here; the count never wraps.
            r_count <= 32'd0;
            r_state <= INT;
          end
        end
        INT: begin
          r_irq   <= 1'b1;
          r_state <= IDLE;
          if (!w_auto) r_ctrl[0] <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_preset = r_preset;
  assign o_count  = r_count;
  assign o_irq    = r_irq;
  assign o_state  = r_state;
endmodule

module mmio_bus_responder #(
  parameter logic [31:0] TC0_BASE     = 32'h0000_7f00,
  parameter logic [31:0] TC1_BASE     = 32'h0000_7f10,
  parameter logic [31:0] INT_ACK_ADDR = 32'h0000_7f20,
  parameter logic [31:0] DM_LIMIT     = 32'h0000_2fff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  input  logic        ext_irq,
  output logic [5:0]  HWInt,
  output logic [1:0]  o_tc0_state,
  output logic [1:0]  o_tc1_state
);
  logic w_dm_hit, w_tc0_hit, w_tc1_hit, w_ack_hit, w_full_wr;
  logic w_tc0_wr_ctrl, w_tc0_wr_preset, w_tc1_wr_ctrl, w_tc1_wr_preset;
  logic w_ack_wr, w_ext_rise;
  logic [3:0]  w_tc0_ctrl, w_tc1_ctrl;
  logic [31:0] w_tc0_preset, w_tc1_preset, w_tc0_count, w_tc1_count;
  logic        w_tc0_irq, w_tc1_irq;
  logic        r_ext_irq_q, r_ext_pending;

  assign w_dm_hit  = (cpu_addr <= DM_LIMIT);
  assign w_tc0_hit = (cpu_addr >= TC0_BASE) && (cpu_addr <= TC0_BASE + 32'd11);
  assign w_tc1_hit = (cpu_addr >= TC1_BASE) && (cpu_addr <= TC1_BASE + 32'd11);
  assign w_ack_hit = (cpu_addr >= INT_ACK_ADDR) && (cpu_addr <= INT_ACK_ADDR + 32'd3);
  // Register space only honours full-word stores; partial stores are dropped.
  assign w_full_wr = (cpu_byteen == 4'b1111);

  assign w_tc0_wr_ctrl   = w_tc0_hit && w_full_wr && (cpu_addr[3:2] == 2'd0);
  assign w_tc0_wr_preset = w_tc0_hit && w_full_wr && (cpu_addr[3:2] == 2'd1);
  assign w_tc1_wr_ctrl   = w_tc1_hit && w_full_wr && (cpu_addr[3:2] == 2'd0);
  assign w_tc1_wr_preset = w_tc1_hit && w_full_wr && (cpu_addr[3:2] == 2'd1);
  assign w_ack_wr        = w_ack_hit && w_full_wr;

  mmio_bus_responder_timer u_tc0 (
    .clk         (clk),
    .rst_n       (reset),
    .i_wr_ctrl   (w_tc0_wr_ctrl),
    .i_wr_preset (w_tc0_wr_preset),
    .i_wdata     (cpu_wdata),
    .o_ctrl      (w_tc0_ctrl),
    .o_preset    (w_tc0_preset),
    .o_count     (w_tc0_count),
    .o_irq       (w_tc0_irq),
    .o_state     (o_tc0_state)
  );

  mmio_bus_responder_timer u_tc1 (
    .clk         (clk),
    .rst_n       (reset),
    .i_wr_ctrl   (w_tc1_wr_ctrl),
    .i_wr_preset (w_tc1_wr_preset),
    .i_wdata     (cpu_wdata),
    .o_ctrl      (w_tc1_ctrl),
    .o_preset    (w_tc1_preset),
    .o_count     (w_tc1_count),
    .o_irq       (w_tc1_irq),
    .o_state     (o_tc1_state)
  );

  assign w_ext_rise = ext_irq && !r_ext_irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_irq_q   <= 1'b0;
      r_ext_pending <= 1'b0;
    end else begin
      r_ext_irq_q <= ext_irq;
      // A fresh edge beats an acknowledge landing in the same cycle.
      if (w_ext_rise)    r_ext_pending <= 1'b1;
      else if (w_ack_wr) r_ext_pending <= 1'b0;
    end
  end

  always_comb begin
    cpu_rdata = 32'd0;
    if (w_dm_hit) begin
      cpu_rdata = dm_rdata;
    end else if (w_tc0_hit) begin
      case (cpu_addr[3:2])
        2'd0:    cpu_rdata = {28'd0, w_tc0_ctrl};
        2'd1:    cpu_rdata = w_tc0_preset;
        2'd2:    cpu_rdata = w_tc0_count;
        default: cpu_rdata = 32'd0;
      endcase
    end else if (w_tc1_hit) begin
      case (cpu_addr[3:2])
        2'd0:    cpu_rdata = {28'd0, w_tc1_ctrl};
        2'd1:    cpu_rdata = w_tc1_preset;
        2'd2:    cpu_rdata = w_tc1_count;
        default: cpu_rdata = 32'd0;
      endcase
    end else if (w_ack_hit) begin
      cpu_rdata = {31'd0, r_ext_pending};
    end
  end

  assign dm_addr   = cpu_addr;
  assign dm_wdata  = cpu_wdata;
  assign dm_byteen = (w_dm_hit && reset) ? cpu_byteen : 4'd0;
  assign HWInt     = {3'b000, r_ext_pending, w_tc1_irq & w_tc1_ctrl[3], w_tc0_irq & w_tc0_ctrl[3]};
endmodule

// File: tb/tb_mmio_bus_responder.sv
// Directed bench for mmio_bus_responder: timers, DM routing, external interrupt
// latch and asynchronous reset, with hand-computed expectations.

module tb_mmio_bus_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = 32'h0000_4000;
  logic [31:0] cpu_wdata = 32'd0;
  logic [3:0]  cpu_byteen = 4'd0;
  logic [31:0] cpu_rdata;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata = 32'hcafe_babe;
  logic        ext_irq = 1'b0;
  logic [5:0]  HWInt;
  logic [1:0]  tc0_state, tc1_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rv;

  logic [31:0] exp_cnt [12] = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0,
                                32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};
  logic [5:0]  exp_hw  [12] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd0,
                                6'd0, 6'd0, 6'd0, 6'd2, 6'd0, 6'd0};

  mmio_bus_responder dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_byteen  (cpu_byteen),
    .cpu_rdata   (cpu_rdata),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_byteen   (dm_byteen),
    .dm_rdata    (dm_rdata),
    .ext_irq     (ext_irq),
    .HWInt       (HWInt),
    .o_tc0_state (tc0_state),
    .o_tc1_state (tc1_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    cpu_addr   = addr;
    cpu_wdata  = data;
    cpu_byteen = be;
    tick();
    cpu_byteen = 4'd0;
    cpu_addr   = 32'h0000_4000;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    cpu_addr   = addr;
    cpu_byteen = 4'd0;
    #1;
    data = cpu_rdata;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_hwint", {26'd0, HWInt}, 32'd0);
    check("rst_tc0_state", {30'd0, tc0_state}, 32'd0);
    rd(32'h7f00, rv); check("rst_tc0_ctrl", rv, 32'd0);
    reset = 1'b1;
    tick();

    // TC0 one-shot, preset 3, IM on
    sw(32'h7f04, 32'd3, 4'hf);
    sw(32'h7f00, 32'h9, 4'hf);                 // edge N
    tick();                                    // N+1: LOAD
    check("tc0_state_load", {30'd0, tc0_state}, 32'd1);
    tick(); rd(32'h7f08, rv); check("tc0_cnt3", rv, 32'd3);
    tick(); rd(32'h7f08, rv); check("tc0_cnt2", rv, 32'd2);
    tick(); rd(32'h7f08, rv); check("tc0_cnt1", rv, 32'd1);
    tick(); rd(32'h7f08, rv); check("tc0_cnt0", rv, 32'd0);
    check("tc0_hw_early", {26'd0, HWInt}, 32'd0);
    tick(); check("tc0_hw_rise", {26'd0, HWInt}, 32'd1);
    rd(32'h7f00, rv); check("tc0_ctrl_en_cleared", rv, 32'h8);
    tick(); tick(); tick();
    check("tc0_hw_held", {26'd0, HWInt}, 32'd1);
    rd(32'h7f08, rv); check("tc0_cnt_stays0", rv, 32'd0);
    sw(32'h7f00, 32'd0, 4'hf);
    #1; check("tc0_hw_dropped", {26'd0, HWInt}, 32'd0);

    // TC1 auto-reload, preset 2
    sw(32'h7f14, 32'd2, 4'hf);
    sw(32'h7f10, 32'hb, 4'hf);                 // edge N
    for (int k = 0; k < 12; k++) begin
      tick();
      rd(32'h7f18, rv);
      check($sformatf("tc1_cnt_k%0d", k + 1), rv, exp_cnt[k]);
      check($sformatf("tc1_hw_k%0d", k + 1), {26'd0, HWInt}, {26'd0, exp_hw[k]});
    end
    rd(32'h7f10, rv); check("tc1_ctrl_kept", rv, 32'hb);
    sw(32'h7f10, 32'd0, 4'hf);

    // DM routing and register byte-enable filtering
    dm_rdata = 32'hcafe_babe;
    cpu_addr = 32'h2ffc; cpu_wdata = 32'h1234_5678; cpu_byteen = 4'hf;
    #1;
    check("dm_byteen_hit", {28'd0, dm_byteen}, 32'hf);
    check("dm_addr", dm_addr, 32'h2ffc);
    check("dm_wdata", dm_wdata, 32'h1234_5678);
    cpu_addr = 32'h3000;
    #1; check("dm_byteen_limit", {28'd0, dm_byteen}, 32'd0);
    check("rd_3000", cpu_rdata, 32'd0);
    cpu_addr = 32'h7f04;
    #1; check("dm_byteen_tc", {28'd0, dm_byteen}, 32'd0);
    tick(); cpu_byteen = 4'd0;
    rd(32'h7f04, rv); check("tc0_preset_sw", rv, 32'h1234_5678);
    sw(32'h7f04, 32'h0000_00ab, 4'b0001);
    rd(32'h7f04, rv); check("tc0_preset_sb", rv, 32'h1234_5678);
    rd(32'h0010, rv); check("dm_read", rv, 32'hcafe_babe);

    // External interrupt
    ext_irq = 1'b1;
    tick(); check("ext_set", {26'd0, HWInt}, 32'h4);
    rd(32'h7f20, rv); check("ack_read1", rv, 32'd1);
    rd(32'h7f23, rv); check("ack_read_b3", rv, 32'd1);
    sw(32'h7f20, 32'd0, 4'b0001);
    #1; check("ext_partial_ack", {26'd0, HWInt}, 32'h4);
    sw(32'h7f20, 32'd0, 4'hf);
    #1; check("ext_acked", {26'd0, HWInt}, 32'd0);
    tick(); check("ext_held_no_reset", {26'd0, HWInt}, 32'd0);
    ext_irq = 1'b0; tick();
    ext_irq = 1'b1; tick();
    check("ext_set2", {26'd0, HWInt}, 32'h4);
    ext_irq = 1'b0; tick();
    ext_irq = 1'b1;
    sw(32'h7f20, 32'd0, 4'hf);
    #1; check("ext_set_beats_ack", {26'd0, HWInt}, 32'h4);
    sw(32'h7f20, 32'd0, 4'hf);
    #1; check("ext_final_ack", {26'd0, HWInt}, 32'd0);
    ext_irq = 1'b0;

    // Unmapped reads and read-only COUNT
    dm_rdata = 32'hdead_beef;
    rd(32'h7f30, rv); check("rd_7f30", rv, 32'd0);
    rd(32'h4000, rv); check("rd_4000", rv, 32'd0);
    rd(32'h7f0c, rv); check("rd_7f0c", rv, 32'd0);
    sw(32'h7f08, 32'hff, 4'hf);
    rd(32'h7f08, rv); check("count_ro", rv, 32'd0);
    rd(32'h7f04, rv); check("preset_untouched", rv, 32'h1234_5678);

    // Async reset mid-count
    sw(32'h7f04, 32'd7, 4'hf);
    sw(32'h7f00, 32'h9, 4'hf);
    ext_irq = 1'b1;
    tick(); tick(); tick(); tick();
    rd(32'h7f08, rv); check("pre_rst_cnt5", rv, 32'd5);
    check("pre_rst_hw", {26'd0, HWInt}, 32'h4);
    #2;
    reset = 1'b0;
    #1;
    check("arst_hwint", {26'd0, HWInt}, 32'd0);
    rd(32'h7f08, rv); check("arst_count", rv, 32'd0);
    rd(32'h7f04, rv); check("arst_preset", rv, 32'd0);
    rd(32'h7f00, rv); check("arst_ctrl", rv, 32'd0);
    cpu_addr = 32'h2ffc; cpu_byteen = 4'hf;
    #1; check("arst_dm_byteen", {28'd0, dm_byteen}, 32'd0);
    cpu_byteen = 4'd0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ext", {26'd0, HWInt}, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mmio_bus_responder.md
Name: mmio_bus_responder

Overview:
Responder for the CPU data-memory port: decodes each CPU data access and routes it to external DM, to one of two internal countdown timers (TC0, TC1), or to the external-interrupt acknowledge register. Merges the timer and external interrupt sources into the 6-bit HWInt vector fed back to the CPU's CP0. Sits between the CPU's MEM stage and the system data memory.

Parameters:
TC0_BASE, 32'h0000_7f00, TC0 register block base (CTRL +0, PRESET +4, COUNT +8)
TC1_BASE, 32'h0000_7f10, TC1 register block base
INT_ACK_ADDR, 32'h0000_7f20, external-interrupt acknowledge word (7f20–7f23)
DM_LIMIT, 32'h0000_2fff, highest DM byte address; DM is 0..DM_LIMIT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_addr  in  32  CPU data address
cpu_wdata  in  32  CPU write data, already byte-lane aligned
cpu_byteen  in  4  byte enables; nonzero = write, 0 = read
cpu_rdata  out  32  read data to CPU, combinational same cycle
dm_addr  out  32  address to DM (= cpu_addr)
dm_wdata  out  32  write data to DM (= cpu_wdata)
dm_byteen  out  4  DM byte enables (cpu_byteen if DM hit, else 0)
dm_rdata  in  32  DM read data, combinational
ext_irq  in  1  external interrupt request level
HWInt  out  6  [0] TC0 irq, [1] TC1 irq, [2] ext pending, [5:3] = 0

Behaviour:
- Reset (reset low, async): TC CTRL = 0, PRESET = 0, COUNT = 0, state IDLE, irq = 0; ext_pending = 0, ext_irq_q = 0. HWInt = 0, dm_byteen = 0.
- Decode (combinational): DM hit = cpu_addr <= DM_LIMIT; TCn hit = TCn_BASE..TCn_BASE+11; ACK hit = 7f20..7f23. cpu_rdata: DM hit -> dm_rdata; TC hit -> register at cpu_addr[3:2] (0 CTRL, 1 PRESET, 2 COUNT); ACK hit -> {31'b0, ext_pending}; else 0.
- Timer writes: only when cpu_byteen == 4'b1111; partial byteen to TC/ACK ignored. COUNT is read-only. Writing CTRL or PRESET takes effect next edge, forces state IDLE and clears that timer's irq.
- CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, others = one-shot), [3] IM (irq output enable). Bits [31:4] read 0.
- Timer FSM, per timer, per cycle, no CPU write this cycle:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: EN=0 -> IDLE (COUNT held). Else COUNT > 1 -> COUNT-1; COUNT <= 1 -> COUNT <= 0, go INT.
  - INT: irq <= 1. MODE one-shot: CTRL.EN <= 0, -> IDLE, irq held until next CTRL/PRESET write. Auto-reload: -> IDLE, irq asserted for exactly the INT-exit cycle, then 0.
- PRESET = 0 or 1: LOAD -> CNT -> INT, same as 1; no wrap to 0xFFFF_FFFF. Count never underflows.
- Latency: EN write at edge N -> LOAD state at N+1, COUNT = PRESET at N+2, irq at N+2+PRESET+1 for PRESET >= 1.
- HWInt[n] = irq_n & CTRL_n.IM (combinational from registers).
- External interrupt: ext_irq_q <= ext_irq each cycle. Rising edge (ext_irq & !ext_irq_q) sets ext_pending. A full-word write to ACK clears it. Same-cycle set and clear: set wins. HWInt[2] = ext_pending.
- Simultaneous CPU write and FSM update on the same timer: the CPU write wins (forces IDLE, clears irq).

Test Plan:
- Reset low mid-count (COUNT = 5) -> all TC registers 0, HWInt = 6'b0 immediately, without waiting for a clock.
- TC0 PRESET = 3, CTRL = 4'b1001 (one-shot, IM) -> COUNT sequence 3, 2, 1, 0. HWInt[0] rises 4 cycles after LOAD and stays high. CTRL reads 4'b1000. Writing CTRL = 0 drops HWInt[0].
- TC1 PRESET = 2, CTRL = 4'b1011 (auto-reload) -> HWInt[1] one-cycle pulse repeating every 5 cycles. COUNT reload to 2 observed each period.
- sw 0x1234_5678 to 0x2ffc -> dm_byteen = 4'b1111, dm_addr = 0x2ffc. sw to 0x7f04 -> dm_byteen = 0, TC0 PRESET = 0x1234_5678. sb to 0x7f04 (byteen 4'b0001) -> PRESET unchanged.
- ext_irq 0 -> 1 -> HWInt[2] = 1 next cycle; lw 0x7f20 reads 1. ext_irq held high does not re-set after a sw to 0x7f20 -> HWInt[2] = 0. New rise in the same cycle as the ack write -> stays 1.
- Read 0x7f30 and 0x4000 -> cpu_rdata = 0, no state change. Write to 0x7f08 (COUNT) ignored.
